// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// default memory depth.
package lsu_pkg;

   localparam int MEM_WORDS_DEF = 256;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_DONE
   } state_e;

   // A request is rejected when its size is illegal or it is not naturally aligned.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] byte_off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = byte_off[0];
         SZ_WORD: bad = (byte_off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between whole memory words and sub-word accesses:
// little-endian extract with sign/zero extension, and lane merge for stores.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  byte_off,
   input  logic [31:0] mem_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [4:0]  byte_lsb;
   logic [4:0]  half_lsb;

   assign byte_lsb  = {byte_off, 3'b000};
   assign half_lsb  = {byte_off[1], 4'b0000};
   assign byte_lane = mem_word[byte_lsb +: 8];
   assign half_lane = mem_word[half_lsb +: 16];

   // NOTE: every output gets a default before the case so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      load_data = mem_word;
      case (size)
         SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
         default: load_data = mem_word;
      endcase
   end

   always_comb begin
      merged = mem_word;
      case (size)
         SZ_BYTE: merged[byte_lsb +: 8]  = wdata[7:0];
         SZ_HALF: merged[half_lsb +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit in front of a word-addressed, level-sensitive memory.
// Sub-word stores are performed as a registered read-modify-write.
module lsu_mem
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_ewr,
   output logic [31:0] mem_dir,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   state_e      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mem_dir_q, mem_dir_d;
   logic [31:0] mem_din_q, mem_din_d;
   logic        mem_ewr_q, mem_ewr_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   logic [31:0] req_idx;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] merged;

   assign req_idx = {2'b00, req_addr[31:2]};
   assign req_err = misaligned(req_size, req_addr[1:0]) || (req_idx >= 32'(MEM_WORDS));

   lsu_align u_align (
      .size        (size_q),
      .is_unsigned (uns_q),
      .byte_off    (off_q),
      .mem_word    (mem_dout),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      mem_dir_d   = mem_dir_q;
      mem_din_d   = mem_din_q;
      mem_ewr_d   = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               size_d      = req_size;
               uns_d       = req_unsigned;
               off_d       = req_addr[1:0];
               wdata_d     = req_wdata;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               if (req_err) begin
                  // Rejected requests never reach the memory pins.
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  mem_dir_d = req_idx;
                  if (!req_we) begin
                     state_d = ST_LOAD;
                  end else if (req_size == SZ_WORD) begin
                     state_d   = ST_WRITE;
                     mem_din_d = req_wdata;
                     mem_ewr_d = 1'b1;
                  end else begin
                     state_d = ST_RMW_RD;
                  end
               end
            end
         end
         ST_LOAD: begin
            state_d     = ST_DONE;
            rsp_rdata_d = load_data;
            rsp_valid_d = 1'b1;
         end
         ST_WRITE: begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
         end
         ST_RMW_RD: begin
            // Merged word and write strobe launch together so both hold for the whole write cycle.
            state_d   = ST_RMW_WR;
            mem_din_d = merged;
            mem_ewr_d = 1'b1;
         end
         ST_RMW_WR: begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            rsp_err_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         wdata_q     <= 32'h0;
         mem_dir_q   <= 32'h0;
         mem_din_q   <= 32'h0;
         mem_ewr_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         mem_dir_q   <= mem_dir_d;
         mem_din_q   <= mem_din_d;
         mem_ewr_q   <= mem_ewr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_ewr   = mem_ewr_q;
   assign mem_dir   = mem_dir_q;
   assign mem_din   = mem_din_q;

endmodule
